// File: rtl/seg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundle between the debug-display scanner and its environment.
//   master : drives data_in, freeze, blank_lz, dp_mask; observes outputs
//   slave  : the scanner; drives o_seg, o_sel, shown, frame_pulse
// Signals:
//   data_in     [4*DIGITS] probe word, nibble i shown on digit i
//   freeze                 hold the captured word at frame start
//   blank_lz               blank leading-zero digits
//   dp_mask     [DIGITS]   bit i lights the dp of digit i
//   o_seg       [8]        {dp,g,f,e,d,c,b,a}
//   o_sel       [DIGITS]   one-hot digit enable
//   shown       [4*DIGITS] word currently displayed
//   frame_pulse            one-cycle pulse at each frame start
// ----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data_in;
    logic                freeze;
    logic                blank_lz;
    logic [DIGITS-1:0]   dp_mask;
    logic [7:0]          o_seg;
    logic [DIGITS-1:0]   o_sel;
    logic [4*DIGITS-1:0] shown;
    logic                frame_pulse;

    modport master (
        output data_in, freeze, blank_lz, dp_mask,
        input  o_seg, o_sel, shown, frame_pulse
    );

    modport slave (
        input  data_in, freeze, blank_lz, dp_mask,
        output o_seg, o_sel, shown, frame_pulse
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Multi-digit seven-segment scan controller for the pipeline debug display.
// A prescaler produces one tick per digit slot; on each tick the next digit
// is selected and its segments are registered. The probe word is captured
// into a shadow register at frame start unless frozen.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : seg_scan_ctrl_if.slave (data_in, freeze, blank_lz, dp_mask in;
//          o_seg, o_sel, shown, frame_pulse out)
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACT_LOW ? '1 : '0;

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        case (n)
            4'h0: f_hex7 = 7'h3F;
            4'h1: f_hex7 = 7'h06;
            4'h2: f_hex7 = 7'h5B;
            4'h3: f_hex7 = 7'h4F;
            4'h4: f_hex7 = 7'h66;
            4'h5: f_hex7 = 7'h6D;
            4'h6: f_hex7 = 7'h7D;
            4'h7: f_hex7 = 7'h07;
            4'h8: f_hex7 = 7'h7F;
            4'h9: f_hex7 = 7'h6F;
            4'hA: f_hex7 = 7'h77;
            4'hB: f_hex7 = 7'h7C;
            4'hC: f_hex7 = 7'h39;
            4'hD: f_hex7 = 7'h5E;
            4'hE: f_hex7 = 7'h79;
            default: f_hex7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [W-1:0]      r_shadow;
    logic              r_frame;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_sel;

    logic              w_tick;
    logic [IW-1:0]     w_nxt;
    logic              w_frame;
    logic              w_capture;
    logic [W-1:0]      w_word;
    logic [W-1:0]      w_upper;
    logic              w_blank;
    logic [7:0]        w_seg_ah;
    logic [DIGITS-1:0] w_sel_ah;

    always_comb begin
        w_tick    = (r_presc == PW'(REFRESH_DIV - 1));
        w_nxt     = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        w_frame   = w_tick && (w_nxt == '0);
        w_capture = w_frame && !bus.freeze;
        // Decode from the word that will be in the shadow after this edge,
        // so digit 0 of a fresh frame shows the newly captured nibble.
        w_word    = w_capture ? bus.data_in : r_shadow;
        // Nibbles nxt..DIGITS-1 all zero <=> the word shifted down is zero.
        w_upper   = w_word >> {w_nxt, 2'b00};
        w_blank   = bus.blank_lz && (w_nxt != '0) && (w_upper == '0);
        w_seg_ah  = w_blank ? 8'h00 : {bus.dp_mask[w_nxt], f_hex7(w_upper[3:0])};
        w_sel_ah  = DIGITS'(1) << w_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc  <= '0;
            r_idx    <= IW'(DIGITS - 1);
            r_shadow <= '0;
            r_frame  <= 1'b0;
            r_seg    <= SEG_OFF;
            r_sel    <= SEL_OFF;
        end else begin
            r_frame <= w_frame;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= w_nxt;
                r_seg   <= w_seg_ah ^ {8{SEG_ACT_LOW}};
                r_sel   <= w_sel_ah ^ {DIGITS{SEL_ACT_LOW}};
                if (w_capture) begin
                    r_shadow <= bus.data_in;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign bus.o_seg       = r_seg;
    assign bus.o_sel       = r_sel;
    assign bus.shown       = r_shadow;
    assign bus.frame_pulse = r_frame;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl. Main instance: DIGITS=8, REFRESH_DIV=4, default
// polarities, followed by a reference model counting clock edges since reset
// release. Second instance: DIGITS=4, REFRESH_DIV=1, active-high selects.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
    localparam int D  = 8;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(D)) if1 ();
    seg_scan_ctrl_if #(.DIGITS(4)) if2 ();

    seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    seg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(1), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Active-high segment pattern of digit d of word w.
    function automatic logic [7:0] ref_seg(input logic [31:0] w, input int unsigned d,
                                           input logic bl, input logic [7:0] dp);
        logic [31:0] up;
        up = w >> (4 * d);
        if (bl && d != 0 && up == 32'h0) return 8'h00;
        return {dp[d], SEG_TAB[up[3:0]]};
    endfunction

    // Reference model: edge k after release is a digit slot when k % RD == 0,
    // showing digit ((k/RD)-1) % D; digit 0 slots start a frame.
    int unsigned m_edges;
    int unsigned m_d;
    logic [31:0] m_w;
    logic [31:0] m_shadow;
    logic [7:0]  m_seg;
    logic [7:0]  m_sel;
    logic        m_frame;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges  <= 0;
            m_shadow <= 32'h0;
            m_seg    <= 8'hFF;
            m_sel    <= 8'hFF;
            m_frame  <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            m_frame <= 1'b0;
            if ((m_edges + 1) % RD == 0) begin
                m_d = ((m_edges + 1) / RD - 1) % D;
                m_w = (m_d == 0 && !if1.freeze) ? if1.data_in : m_shadow;
                if (m_d == 0) begin
                    m_frame  <= 1'b1;
                    m_shadow <= m_w;
                end
                m_sel <= ~(8'd1 << m_d);
                m_seg <= ~ref_seg(m_w, m_d, if1.blank_lz, if1.dp_mask);
            end
        end
    end

    task automatic wait_frame(input string tag);
        int unsigned k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (if1.frame_pulse !== 1'b1 && k < 100);
        n_checks++;
        if (if1.frame_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame wait: frame_pulse=%b, required 1 within 100 cycles", tag, if1.frame_pulse);
        end
    endtask

    task automatic wait_digit(input int unsigned d, input string tag);
        logic [7:0] want;
        int unsigned k;
        want = ~(8'd1 << d);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (if1.o_sel !== want && k < 100);
        n_checks++;
        if (if1.o_sel !== want) begin
            n_fail++;
            $display("FAIL %s digit wait: o_sel=%h, required %h within 100 cycles", tag, if1.o_sel, want);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #3;
        n_checks += 4;
        if (if1.o_sel !== 8'hFF) begin n_fail++; $display("FAIL reset o_sel: got %h, required ff", if1.o_sel); end
        if (if1.o_seg !== 8'hFF) begin n_fail++; $display("FAIL reset o_seg: got %h, required ff", if1.o_seg); end
        if (if1.shown !== 32'h0) begin n_fail++; $display("FAIL reset shown: got %h, required 0", if1.shown); end
        if (if1.frame_pulse !== 1'b0) begin n_fail++; $display("FAIL reset frame_pulse: got %b, required 0", if1.frame_pulse); end
    endtask

    task automatic test_first_frame(input string tag);
        if1.data_in = 32'h0123ABCF;
        if1.freeze = 1'b0; if1.blank_lz = 1'b0; if1.dp_mask = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (if1.o_sel !== 8'hFF) begin n_fail++; $display("FAIL %s pre-tick o_sel: got %h, required ff", tag, if1.o_sel); end
        if (if1.frame_pulse !== 1'b0) begin n_fail++; $display("FAIL %s pre-tick frame_pulse: got %b, required 0", tag, if1.frame_pulse); end
        @(negedge clk);
        n_checks += 4;
        if (if1.o_sel !== 8'hFE) begin n_fail++; $display("FAIL %s tick1 o_sel: got %h, required fe", tag, if1.o_sel); end
        if (if1.o_seg !== 8'h8E) begin n_fail++; $display("FAIL %s tick1 o_seg: got %h, required 8e", tag, if1.o_seg); end
        if (if1.frame_pulse !== 1'b1) begin n_fail++; $display("FAIL %s tick1 frame_pulse: got %b, required 1", tag, if1.frame_pulse); end
        if (if1.shown !== 32'h0123ABCF) begin n_fail++; $display("FAIL %s tick1 shown: got %h, required 0123abcf", tag, if1.shown); end
        repeat (4) @(negedge clk);
        n_checks += 3;
        if (if1.o_sel !== 8'hFD) begin n_fail++; $display("FAIL %s tick2 o_sel: got %h, required fd", tag, if1.o_sel); end
        if (if1.o_seg !== 8'hC6) begin n_fail++; $display("FAIL %s tick2 o_seg: got %h, required c6", tag, if1.o_seg); end
        if (if1.frame_pulse !== 1'b0) begin n_fail++; $display("FAIL %s tick2 frame_pulse: got %b, required 0", tag, if1.frame_pulse); end
    endtask

    task automatic test_full_frame();
        logic [7:0] seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        int unsigned pulses;
        pulses = 0;
        wait_frame("full_frame");
        for (int c = 0; c < 32; c++) begin
            if (if1.frame_pulse === 1'b1) pulses++;
            if (c % 4 == 0) begin
                n_checks++;
                if (if1.o_sel !== seq[c / 4]) begin
                    n_fail++;
                    $display("FAIL full_frame o_sel slot %0d: got %h, required %h", c / 4, if1.o_sel, seq[c / 4]);
                end
            end
            @(negedge clk);
        end
        n_checks += 2;
        if (if1.o_sel !== 8'hFE) begin n_fail++; $display("FAIL full_frame wrap o_sel: got %h, required fe", if1.o_sel); end
        if (pulses != 1) begin n_fail++; $display("FAIL full_frame pulse count: got %0d, required 1", pulses); end
    endtask

    task automatic test_freeze();
        wait_digit(3, "freeze");
        if1.freeze = 1'b1;
        if1.data_in = 32'hFFFFFFFF;
        wait_frame("freeze_hold");
        n_checks += 2;
        if (if1.shown !== 32'h0123ABCF) begin n_fail++; $display("FAIL freeze hold shown: got %h, required 0123abcf", if1.shown); end
        if (if1.o_seg !== 8'h8E) begin n_fail++; $display("FAIL freeze hold digit0: got %h, required 8e", if1.o_seg); end
        wait_digit(2, "freeze_d2");
        n_checks++;
        if (if1.o_seg !== 8'h83) begin n_fail++; $display("FAIL freeze hold digit2: got %h, required 83", if1.o_seg); end
        wait_digit(4, "unfreeze");
        if1.freeze = 1'b0;
        wait_frame("unfreeze_cap");
        n_checks++;
        if (if1.shown !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL unfreeze shown: got %h, required ffffffff", if1.shown); end
        for (int c = 0; c < 32; c++) begin
            n_checks++;
            if (if1.o_seg !== 8'h8E) begin n_fail++; $display("FAIL unfreeze o_seg cycle %0d: got %h, required 8e", c, if1.o_seg); end
            @(negedge clk);
        end
    endtask

    // Checks one frame where each digit's expected pattern is given by table.
    task automatic check_frame(input string tag, input logic [7:0] exp_tab [8]);
        int d;
        for (int c = 0; c < 32; c++) begin
            d = -1;
            for (int i = 0; i < 8; i++) if (if1.o_sel === ~(8'd1 << i)) d = i;
            n_checks++;
            if (d < 0) begin
                n_fail++;
                $display("FAIL %s o_sel one-hot: got %h, required a single low bit", tag, if1.o_sel);
            end else if (if1.o_seg !== exp_tab[d]) begin
                n_fail++;
                $display("FAIL %s digit %0d o_seg: got %h, required %h", tag, d, if1.o_seg, exp_tab[d]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        logic [7:0] t50 [8] = '{8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] t00 [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        if1.data_in = 32'h00000050;
        if1.blank_lz = 1'b1;
        wait_frame("blank50");
        check_frame("blank50", t50);
        if1.data_in = 32'h0;
        wait_frame("blank0");
        check_frame("blank0", t00);
    endtask

    task automatic test_dp();
        logic [7:0] tdp [8] = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        if1.blank_lz = 1'b0;
        if1.dp_mask = 8'h01;
        if1.data_in = 32'h0;
        wait_frame("dp");
        check_frame("dp", tdp);
    endtask

    task automatic test_async_reset();
        wait_digit(5, "async");
        #2 rst = 1'b0;
        #1;
        n_checks += 4;
        if (if1.o_sel !== 8'hFF) begin n_fail++; $display("FAIL async o_sel: got %h, required ff", if1.o_sel); end
        if (if1.o_seg !== 8'hFF) begin n_fail++; $display("FAIL async o_seg: got %h, required ff", if1.o_seg); end
        if (if1.shown !== 32'h0) begin n_fail++; $display("FAIL async shown: got %h, required 0", if1.shown); end
        if (if1.frame_pulse !== 1'b0) begin n_fail++; $display("FAIL async frame_pulse: got %b, required 0", if1.frame_pulse); end
        test_first_frame("async_restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (if1.o_seg !== m_seg) begin n_fail++; $display("FAIL random o_seg cycle %0d: got %h, required %h", i, if1.o_seg, m_seg); end
            if (if1.o_sel !== m_sel) begin n_fail++; $display("FAIL random o_sel cycle %0d: got %h, required %h", i, if1.o_sel, m_sel); end
            if (if1.shown !== m_shadow) begin n_fail++; $display("FAIL random shown cycle %0d: got %h, required %h", i, if1.shown, m_shadow); end
            if (if1.frame_pulse !== m_frame) begin n_fail++; $display("FAIL random frame_pulse cycle %0d: got %b, required %b", i, if1.frame_pulse, m_frame); end
            if1.data_in  = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(0, 8)));
            if1.blank_lz = 1'($urandom_range(0, 1));
            if1.dp_mask  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) if1.freeze = ~if1.freeze;
        end
        if1.freeze = 1'b0;
    endtask

    task automatic test_sweep();
        logic [15:0] w;
        logic [7:0]  want_seg;
        int unsigned d;
        w = 16'($urandom);
        if2.data_in = w;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            d = k % 4;
            want_seg = ~{1'b0, SEG_TAB[4'(w >> (4 * d))]};
            n_checks += 3;
            if (if2.o_sel !== 4'(1 << d)) begin n_fail++; $display("FAIL sweep o_sel cycle %0d: got %h, required %h", k, if2.o_sel, 4'(1 << d)); end
            if (if2.frame_pulse !== (d == 0)) begin n_fail++; $display("FAIL sweep frame_pulse cycle %0d: got %b, required %b", k, if2.frame_pulse, d == 0); end
            if (if2.o_seg !== want_seg) begin n_fail++; $display("FAIL sweep o_seg cycle %0d: got %h, required %h", k, if2.o_seg, want_seg); end
        end
    endtask

    initial begin
        if1.data_in = 32'h0; if1.freeze = 1'b0; if1.blank_lz = 1'b0; if1.dp_mask = 8'h00;
        if2.data_in = 16'h0; if2.freeze = 1'b0; if2.blank_lz = 1'b0; if2.dp_mask = 4'h0;
        test_reset();
        test_first_frame("first_frame");
        test_full_frame();
        test_freeze();
        test_blanking();
        test_dp();
        test_async_reset();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multi-digit seven-segment scan controller for the pipeline debug display.
- Takes a probe word (register or PC value selected upstream) and time-multiplexes it as hex digits onto shared segment lines.
- Supports freeze (the debug `stop` path), leading-zero blanking, per-digit decimal points and selectable output polarity.
- Replaces the fixed 8-digit scanner in pipe_top.

Parameters:
- DIGITS, 8, number of digits scanned; 1..16. Data width is 4*DIGITS (derived, not a parameter).
- REFRESH_DIV, 100000, clk cycles per digit slot; >=1.
- SEG_ACT_LOW, 1, 1 = segment/dp lines low-active.
- SEL_ACT_LOW, 1, 1 = digit-select lines low-active.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- data_in  in  4*DIGITS  probe word; nibble i shown on digit i, digit 0 = least significant.
- freeze  in  1  1 = hold the captured word, no new captures.
- blank_lz  in  1  1 = blank leading-zero digits.
- dp_mask  in  DIGITS  bit i lights the dp of digit i.
- o_seg  out  8  {dp,g,f,e,d,c,b,a}.
- o_sel  out  DIGITS  one-hot digit enable.
- shown  out  4*DIGITS  word currently being displayed (shadow register).
- frame_pulse  out  1  one-cycle pulse on each frame start.

Behaviour:
- Reset (async, while rst=0):
  - prescaler = 0, idx = DIGITS-1, shadow = 0, frame_pulse = 0.
  - o_sel = all digits off (all 1s when SEL_ACT_LOW).
  - o_seg = all segments off (8'hFF when SEG_ACT_LOW).
- Prescaler:
  - counts 0..REFRESH_DIV-1; tick = (prescaler == REFRESH_DIV-1); wraps to 0 on tick.
  - REFRESH_DIV=1 gives a tick every cycle.
- On tick, idx advances to nxt = (idx==DIGITS-1) ? 0 : idx+1. o_sel and o_seg are registered and update on the same edge to reflect nxt. No other output changes between ticks.
- Frame start is a tick with nxt==0:
  - frame_pulse=1 for that cycle only.
  - If freeze=0, shadow <= data_in, and o_seg for digit 0 is decoded from data_in[3:0] on that same edge (no stale first digit).
  - If freeze=1, shadow holds.
- Freeze is only sampled at frame start. Toggling freeze mid-frame never tears a frame. The first tick after reset is a frame start, so the first lit digit is 0.
- Decode (active-high form, before polarity), digits 0..F:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - Bit 7 = dp_mask[nxt], sampled at the tick.
- Blanking: when blank_lz=1, digit i>0 is blanked (segments and dp off, select still driven) if shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. blank_lz and dp_mask are sampled per tick and take effect on the next digit.
- Polarity: final o_seg = SEG_ACT_LOW ? ~active_high : active_high. o_sel is treated the same way with SEL_ACT_LOW.
- Exactly one select is active at any time after the first tick; never zero and never two.
- rst asserted mid-scan returns every output to its reset value immediately. Scan restarts with a fresh capture on the first tick after release.

Test Plan:
- Common setup: DIGITS=8, REFRESH_DIV=4, polarities default.
- Reset then data_in=32'h0123ABCF:
  - first tick at cycle 4 after release: o_sel=8'hFE, o_seg=8'h8E (F), frame_pulse=1, shown=32'h0123ABCF.
  - next tick: o_sel=8'hFD, o_seg=8'hC6 (C).
- Full frame: 8 ticks cycle o_sel through FE,FD,FB,F7,EF,DF,BF,7F then back to FE. frame_pulse is seen once per 32 cycles.
- Freeze: set freeze=1 at digit 3 and change data_in to 32'hFFFFFFFF.
  - Next frame still shows 0123ABCF.
  - Clear freeze mid-frame: the following frame start captures FFFFFFFF, and every digit shows 8'h8E.
- Blanking: data_in=32'h00000050, blank_lz=1.
  - Digits 2..7 show 8'hFF, digit 1 shows 8'h92 (5), digit 0 shows 8'hC0.
  - data_in=0 leaves only digit 0 lit, showing 8'hC0.
- dp_mask=8'h01, data_in=0 -> digit 0 shows 8'h40, other digits 8'hC0.
- Async reset pulse mid-digit 5: o_sel=8'hFF and o_seg=8'hFF within the same cycle with no clock edge. After release, capture and digit-0 display restart per the first scenario.
- Parameter sweep with DIGITS=4, REFRESH_DIV=1, SEL_ACT_LOW=0: o_sel cycles 1,2,4,8 on consecutive cycles. frame_pulse fires every 4 cycles.
